ex_stage: RTL and testbench

Execute stage of the 5-stage RISC-V pipeline, directly downstream of the ID/EX pipeline register. Consumes the E-stage control and data fields, applies operand forwarding, computes the ALU result and branch/jump target, and resolves control flow (PCSrcE). It also owns the EX/MEM pipeline register, so every M-stage signal it produces is registered. Optional performance counters track control-transfer activity.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/alu.sv | 32 +++
 rtl/ex_stage.sv | 143 ++++++++++++++
 tb/tb_ex_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcodes, forward selects, ResultSrc codes, EX/MEM record.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SLTU  = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    // Forward selects from the hazard unit; 2'b11 is unused and falls back to the register file.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Writeback result source encodings carried through M.
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Everything the EX/MEM register hands to the memory stage.
    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
    } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/logic/set-less-than/pass-B with zero flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows inputs.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [2:0]      alu_ctl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    // Operation select; comparisons yield a zero-extended 0/1.
    always_comb begin
        result = '0;
        unique case (alu_op_e'(alu_ctl))
            ALU_ADD:   result = src_a + src_b;
            ALU_SUB:   result = src_a - src_b;
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_PASSB: result = src_b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch/jump resolution, EX/MEM register; optional counters (EX_PERF_EN).
// Latency: PCSrcE/PCTargetE combinational; M outputs one cycle after E inputs.
// Backpressure: none; no stall input, EX/MEM captures every cycle, bubbles pass through as zeros.
module ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ResultSrcE,
    input  logic            MemWriteE,
    input  logic            RegWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            JALRSrcE,
    input  logic            ALUSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic [31:0]     BrCountM,
    output logic [31:0]     BrTakenCountM,
    output logic [31:0]     JumpCountM
);

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result_e;
    logic [XLEN-1:0] jalr_sum_e;
    logic            zero_e;
    logic            br_taken_e;
    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;

    // Operand forwarding; the M-stage source is last cycle's registered ALU result.
    always_comb begin
        src_a_e      = RD1E;
        write_data_e = RD2E;
        case (ForwardAE)
            FWD_M:   src_a_e = ex_mem_q.alu_result;
            FWD_W:   src_a_e = ResultW;
            default: src_a_e = RD1E;
        endcase
        case (ForwardBE)
            FWD_M:   write_data_e = ex_mem_q.alu_result;
            FWD_W:   write_data_e = ResultW;
            default: write_data_e = RD2E;
        endcase
        src_b_e = ALUSrcE ? ExtImmE : write_data_e;
    end

    alu u_alu (
        .src_a   (src_a_e),
        .src_b   (src_b_e),
        .alu_ctl (ALUControlE),
        .result  (alu_result_e),
        .zero    (zero_e)
    );

    // Control-flow resolution; BEQ arrives as SUB so only the zero condition matters.
    always_comb begin
        br_taken_e = BranchE & zero_e;
        PCSrcE     = JumpE | br_taken_e;
        jalr_sum_e = src_a_e + ExtImmE;
        PCTargetE  = JALRSrcE ? {jalr_sum_e[XLEN-1:1], 1'b0} : (PCE + ExtImmE);
    end

    // Next EX/MEM contents: straight capture of the E-stage values.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = RegWriteE;
        ex_mem_d.mem_write  = MemWriteE;
        ex_mem_d.result_src = ResultSrcE;
        ex_mem_d.alu_result = alu_result_e;
        ex_mem_d.write_data = write_data_e;
        ex_mem_d.pc_plus4   = PCPlus4E;
        ex_mem_d.rd         = RdE;
    end

    // EX/MEM register; synchronous reset wins over capture.
    always_ff @(posedge clk) begin
        if (rst) ex_mem_q <= '0;
        else     ex_mem_q <= ex_mem_d;
    end

    assign RegWriteM  = ex_mem_q.reg_write;
    assign MemWriteM  = ex_mem_q.mem_write;
    assign ResultSrcM = ex_mem_q.result_src;
    assign ALUResultM = ex_mem_q.alu_result;
    assign WriteDataM = ex_mem_q.write_data;
    assign PCPlus4M   = ex_mem_q.pc_plus4;
    assign RdM        = ex_mem_q.rd;

`ifdef EX_PERF_EN
    logic [31:0] br_cnt_q,  br_cnt_d;
    logic [31:0] brt_cnt_q, brt_cnt_d;
    logic [31:0] jmp_cnt_q, jmp_cnt_d;

    // Free-running wrap-around event counters.
    always_comb begin
        br_cnt_d  = br_cnt_q  + {31'd0, BranchE};
        brt_cnt_d = brt_cnt_q + {31'd0, br_taken_e};
        jmp_cnt_d = jmp_cnt_q + {31'd0, JumpE};
    end

    // Counter registers; reset suppresses the same-edge increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            brt_cnt_q <= '0;
            jmp_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            brt_cnt_q <= brt_cnt_d;
            jmp_cnt_q <= jmp_cnt_d;
        end
    end

    assign BrCountM      = br_cnt_q;
    assign BrTakenCountM = brt_cnt_q;
    assign JumpCountM    = jmp_cnt_q;
`else
    assign BrCountM      = '0;
    assign BrTakenCountM = '0;
    assign JumpCountM    = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: scoreboard of expected EX/MEM contents plus combinational redirect checks.
// Latency: expects M outputs one edge after the E inputs are driven.
// Backpressure: none exercised; the stage accepts every cycle.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE, RegWriteE, JumpE, BranchE, JALRSrcE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ExtImmE, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic [31:0] BrCountM, BrTakenCountM, JumpCountM;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rw, mw;
        logic [1:0]  rs;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic [31:0] bc, btc, jc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_alu = '0;
    logic [31:0] m_bc  = '0;
    logic [31:0] m_btc = '0;
    logic [31:0] m_jc  = '0;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .RegWriteE(RegWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .JALRSrcE(JALRSrcE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .BrCountM(BrCountM), .BrTakenCountM(BrTakenCountM), .JumpCountM(JumpCountM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
        case (sel)
            2'b10:   return m_alu;
            2'b01:   return ResultW;
            default: return rf;
        endcase
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    task automatic clr();
        rst = 1'b0; ResultSrcE = '0; MemWriteE = 0; RegWriteE = 0; JumpE = 0; BranchE = 0;
        JALRSrcE = 0; ALUSrcE = 0; ALUControlE = '0; PCE = '0; PCPlus4E = '0; RD1E = '0;
        RD2E = '0; ExtImmE = '0; RdE = '0; ForwardAE = '0; ForwardBE = '0; ResultW = '0;
    endtask

    // Model the current E inputs, check redirect, push expected M state, clock, pop and compare.
    task automatic cycle(input string tag);
        logic [31:0] a, wd, b, res, tgt, s;
        logic        pcsrc, taken;
        exp_t        e, got;
        #1;
        a     = fwd(ForwardAE, RD1E);
        wd    = fwd(ForwardBE, RD2E);
        b     = ALUSrcE ? ExtImmE : wd;
        res   = alu_ref(ALUControlE, a, b);
        taken = BranchE & (res == 32'd0);
        pcsrc = JumpE | taken;
        s     = a + ExtImmE;
        tgt   = JALRSrcE ? (s & 32'hFFFF_FFFE) : (PCE + ExtImmE);
        check({tag, ".pcsrc"}, {31'd0, PCSrcE}, {31'd0, pcsrc});
        check({tag, ".target"}, PCTargetE, tgt);
        if (rst) begin
            e = '{rw: 0, mw: 0, rs: 0, alu: 0, wd: 0, pc4: 0, rd: 0, bc: 0, btc: 0, jc: 0};
            m_bc = 0; m_btc = 0; m_jc = 0;
        end else begin
`ifdef EX_PERF_EN
            m_bc  = m_bc  + {31'd0, BranchE};
            m_btc = m_btc + {31'd0, taken};
            m_jc  = m_jc  + {31'd0, JumpE};
`endif
            e = '{rw: RegWriteE, mw: MemWriteE, rs: ResultSrcE, alu: res, wd: wd, pc4: PCPlus4E,
                  rd: RdE, bc: m_bc, btc: m_btc, jc: m_jc};
        end
        m_alu = e.alu;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".RegWriteM"}, {31'd0, RegWriteM}, {31'd0, got.rw});
        check({tag, ".MemWriteM"}, {31'd0, MemWriteM}, {31'd0, got.mw});
        check({tag, ".ResultSrcM"}, {30'd0, ResultSrcM}, {30'd0, got.rs});
        check({tag, ".ALUResultM"}, ALUResultM, got.alu);
        check({tag, ".WriteDataM"}, WriteDataM, got.wd);
        check({tag, ".PCPlus4M"}, PCPlus4M, got.pc4);
        check({tag, ".RdM"}, {27'd0, RdM}, {27'd0, got.rd});
        check({tag, ".BrCountM"}, BrCountM, got.bc);
        check({tag, ".BrTakenCountM"}, BrTakenCountM, got.btc);
        check({tag, ".JumpCountM"}, JumpCountM, got.jc);
    endtask

    initial begin
        clr();
        @(negedge clk);
        // Reset with random E inputs.
        rst = 1; ResultSrcE = 2'b10; MemWriteE = 1; RegWriteE = 1; BranchE = 1; JumpE = 1;
        ALUControlE = 3'($urandom); RD1E = $urandom; RD2E = $urandom; RdE = 5'($urandom);
        PCPlus4E = $urandom; PCE = $urandom; ExtImmE = $urandom;
        cycle("reset");
        // SUB 5-7.
        clr(); ALUControlE = 3'd1; RD1E = 5; RD2E = 7; RdE = 5'd3; RegWriteE = 1;
        cycle("sub");
        check("sub.value", ALUResultM, 32'hFFFF_FFFE);
        // ADD 3+4 into x5, then forward it from M.
        clr(); ALUControlE = 3'd0; RD1E = 3; RD2E = 4; RdE = 5'd5; RegWriteE = 1;
        cycle("add");
        clr(); ForwardAE = 2'b10; ExtImmE = 1; ALUSrcE = 1; RdE = 5'd6; RegWriteE = 1;
        cycle("fwd_m");
        check("fwd_m.value", ALUResultM, 32'd8);
        // Store data forwarded from W.
        clr(); ForwardBE = 2'b01; ResultW = 32'h55; RD2E = 32'h99; MemWriteE = 1; ResultSrcE = 2'b01;
        ALUSrcE = 1; ExtImmE = 32'h10;
        cycle("fwd_w");
        check("fwd_w.value", WriteDataM, 32'h55);
        // Taken branch 9-9.
        clr(); BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 9; PCE = 32'h100; ExtImmE = 32'h20;
        #1;
        check("br_taken.pcsrc_abs", {31'd0, PCSrcE}, 32'd1);
        check("br_taken.target_abs", PCTargetE, 32'h120);
        cycle("br_taken");
        // Not-taken branch.
        clr(); BranchE = 1; ALUControlE = 3'd1; RD1E = 9; RD2E = 8; PCE = 32'h200; ExtImmE = 32'h40;
        cycle("br_not");
        // JALR.
        clr(); JumpE = 1; JALRSrcE = 1; RD1E = 32'h203; ExtImmE = 4; ALUSrcE = 1;
        PCPlus4E = 32'h10C; RdE = 5'd1; RegWriteE = 1; ResultSrcE = 2'b10;
        #1;
        check("jalr.target_abs", PCTargetE, 32'h206);
        cycle("jalr");
        check("jalr.pc4_abs", PCPlus4M, 32'h10C);
        // Signed vs unsigned compare on -1 vs 1.
        clr(); ALUControlE = 3'd5; RD1E = 32'hFFFF_FFFF; RD2E = 1;
        cycle("slt");
        check("slt.value", ALUResultM, 32'd1);
        clr(); ALUControlE = 3'd6; RD1E = 32'hFFFF_FFFF; RD2E = 1;
        cycle("sltu");
        check("sltu.value", ALUResultM, 32'd0);
        // Select 11 behaves as register file.
        clr(); ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h1234; RD2E = 32'h0F0F;
        ResultW = 32'hDEAD; ALUControlE = 3'd3; MemWriteE = 1;
        cycle("fwd_11");
        // Same-edge reset during a taken branch.
        clr(); rst = 1; BranchE = 1; ALUControlE = 3'd1; RD1E = 4; RD2E = 4; PCE = 32'h40;
        ExtImmE = 8; RegWriteE = 1; RdE = 5'd9;
        cycle("rst_branch");
        // Random mix.
        for (int i = 0; i < 80; i++) begin
            clr();
            ResultSrcE = 2'($urandom); MemWriteE = 1'($urandom); RegWriteE = 1'($urandom);
            JumpE = ($urandom_range(0, 3) == 0); BranchE = ($urandom_range(0, 2) == 0);
            JALRSrcE = 1'($urandom); ALUSrcE = 1'($urandom); ALUControlE = 3'($urandom);
            PCE = $urandom; PCPlus4E = $urandom; RD1E = $urandom; RdE = 5'($urandom);
            RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
            ExtImmE = $urandom; ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            ResultW = $urandom;
            cycle("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
